// File: rtl/mc_seq_ctrl.sv
// Multicycle control sequencer: steps each instruction through IF/ID/EX/MEM/WB and drives the datapath enables.
// Optional MC_SEQ_PERF_EN adds the cycle (cyc_cnt) and retired-instruction (ret_cnt) counters.
module mc_seq_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  op_class,
    input  logic        link,
    input  logic        br_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        pc_wr,
    output logic        pc_rd,
    output logic [1:0]  pc_src,
    output logic        ir_wr,
    output logic        ab_wr,
    output logic        z_wr,
    output logic        mdr_wr,
    output logic        rf_wr,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        halted,
    output logic [1:0]  err
`ifdef MC_SEQ_PERF_EN
    ,
    output logic [31:0] cyc_cnt,
    output logic [31:0] ret_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [2:0] OP_ALU    = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_STORE  = 3'd2;
    localparam logic [2:0] OP_BRANCH = 3'd3;
    localparam logic [2:0] OP_JUMP   = 3'd4;
    localparam logic [2:0] OP_HALT   = 3'd5;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    localparam bit          TO_EN  = (TIMEOUT != 0);
    localparam logic [TW-1:0] TO_CNT = TW'(TIMEOUT);

    state_t        r_state;
    state_t        w_next;
    logic [TW-1:0] r_wait;
    logic [TW-1:0] w_waitNext;
    logic [1:0]    r_err;
    logic [1:0]    w_errNext;
    logic          w_timeout;

    logic       w_memReq;
    logic       w_memWe;
    logic       w_pcWr;
    logic       w_pcRd;
    logic [1:0] w_pcSrc;
    logic       w_irWr;
    logic       w_abWr;
    logic       w_zWr;
    logic       w_mdrWr;
    logic       w_rfWr;
    logic [1:0] w_wbSel;

    assign w_timeout = TO_EN && (r_wait == TO_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IF;
            r_wait  <= '0;
            r_err   <= ERR_NONE;
        end else begin
            r_state <= w_next;
            r_wait  <= w_waitNext;
            r_err   <= w_errNext;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_waitNext = r_wait;
        w_errNext  = r_err;
        w_memReq   = 1'b0;
        w_memWe    = 1'b0;
        w_pcWr     = 1'b0;
        w_pcRd     = 1'b0;
        w_pcSrc    = 2'd0;
        w_irWr     = 1'b0;
        w_abWr     = 1'b0;
        w_zWr      = 1'b0;
        w_mdrWr    = 1'b0;
        w_rfWr     = 1'b0;
        w_wbSel    = 2'd0;

        case (r_state)
            S_IF: begin
                w_memReq = 1'b1;
                w_pcRd   = 1'b1;
                if (mem_ready) begin
                    w_irWr  = 1'b1;
                    w_pcWr  = 1'b1;
                    w_pcSrc = 2'd0;
                    w_next  = S_ID;
                end else if (w_timeout) begin
                    w_next    = S_HALT;
                    w_errNext = ERR_TIMEOUT;
                end else begin
                    w_waitNext = r_wait + 1'b1;
                end
            end
            S_ID: begin
                w_abWr = 1'b1;
                case (op_class)
                    OP_ALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JUMP: w_next = S_EX;
                    OP_HALT: w_next = S_HALT;
                    default: begin
                        w_next    = S_HALT;
                        w_errNext = ERR_ILLEGAL;
                    end
                endcase
            end
            S_EX: begin
                case (op_class)
                    OP_ALU: begin
                        w_zWr  = 1'b1;
                        w_next = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        w_zWr  = 1'b1;
                        w_next = S_MEM;
                    end
                    OP_BRANCH: begin
                        w_pcWr  = br_taken;
                        w_pcSrc = 2'd1;
                        w_next  = S_IF;
                    end
                    OP_JUMP: begin
                        // Return address comes from the datapath link latch, so PC may update now.
                        w_pcWr  = 1'b1;
                        w_pcSrc = 2'd2;
                        w_next  = link ? S_WB : S_IF;
                    end
                    default: begin
                        w_next    = S_HALT;
                        w_errNext = ERR_ILLEGAL;
                    end
                endcase
            end
            S_MEM: begin
                w_memReq = 1'b1;
                w_memWe  = (op_class == OP_STORE);
                if (mem_ready) begin
                    if (op_class == OP_LOAD) begin
                        w_mdrWr = 1'b1;
                        w_next  = S_WB;
                    end else begin
                        w_next = S_IF;
                    end
                end else if (w_timeout) begin
                    w_next    = S_HALT;
                    w_errNext = ERR_TIMEOUT;
                end else begin
                    w_waitNext = r_wait + 1'b1;
                end
            end
            S_WB: begin
                w_rfWr = 1'b1;
                if (op_class == OP_LOAD) begin
                    w_wbSel = 2'd1;
                end else if (op_class == OP_JUMP && link) begin
                    w_wbSel = 2'd2;
                end
                w_next = S_IF;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_IF;
            end
        endcase

        if (w_next != r_state || mem_ready) begin
            w_waitNext = '0;
        end
    end

    // Reset masks every output, including the registered status ones.
    assign mem_req = w_memReq & ~rst;
    assign mem_we  = w_memWe & ~rst;
    assign pc_wr   = w_pcWr & ~rst;
    assign pc_rd   = w_pcRd & ~rst;
    assign pc_src  = rst ? 2'd0 : w_pcSrc;
    assign ir_wr   = w_irWr & ~rst;
    assign ab_wr   = w_abWr & ~rst;
    assign z_wr    = w_zWr & ~rst;
    assign mdr_wr  = w_mdrWr & ~rst;
    assign rf_wr   = w_rfWr & ~rst;
    assign wb_sel  = rst ? 2'd0 : w_wbSel;
    assign state   = rst ? 3'd0 : r_state;
    assign halted  = ~rst & (r_state == S_HALT);
    assign err     = rst ? ERR_NONE : r_err;

`ifdef MC_SEQ_PERF_EN
    logic [31:0] r_cycCnt;
    logic [31:0] r_retCnt;
    logic        w_retire;

    assign w_retire = (w_next == S_IF) &&
                      (r_state == S_EX || r_state == S_MEM || r_state == S_WB);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycCnt <= '0;
            r_retCnt <= '0;
        end else begin
            if (r_state != S_HALT) begin
                r_cycCnt <= r_cycCnt + 32'd1;
            end
            if (w_retire) begin
                r_retCnt <= r_retCnt + 32'd1;
            end
        end
    end

    assign cyc_cnt = rst ? 32'd0 : r_cycCnt;
    assign ret_cnt = rst ? 32'd0 : r_retCnt;
`endif

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Scoreboard bench for mc_seq_ctrl: a transaction-level model expands each instruction into
// expected per-cycle outputs; a monitor compares them against the DUT on the falling edge.
module tb_mc_seq_ctrl;

    localparam int TIMEOUT = 4;
    localparam int TW      = 8;

    typedef struct packed {
        logic       memReq;
        logic       memWe;
        logic       pcWr;
        logic       pcRd;
        logic [1:0] pcSrc;
        logic       irWr;
        logic       abWr;
        logic       zWr;
        logic       mdrWr;
        logic       rfWr;
        logic [1:0] wbSel;
        logic [2:0] state;
        logic       halted;
        logic [1:0] err;
    } outs_t;

    logic       clk;
    logic       rst;
    logic [2:0] op_class;
    logic       link;
    logic       br_taken;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       pc_wr;
    logic       pc_rd;
    logic [1:0] pc_src;
    logic       ir_wr;
    logic       ab_wr;
    logic       z_wr;
    logic       mdr_wr;
    logic       rf_wr;
    logic [1:0] wb_sel;
    logic [2:0] state;
    logic       halted;
    logic [1:0] err;
`ifdef MC_SEQ_PERF_EN
    logic [31:0] cyc_cnt;
    logic [31:0] ret_cnt;
`endif

    outs_t expQ[$];
    string nameQ[$];
    int    testsRun = 0;
    int    testsFailed = 0;
    logic [1:0] mErr = 2'd0;
    bit    driverDone = 0;

    mc_seq_ctrl #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk(clk), .rst(rst), .op_class(op_class), .link(link), .br_taken(br_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .pc_wr(pc_wr),
        .pc_rd(pc_rd), .pc_src(pc_src), .ir_wr(ir_wr), .ab_wr(ab_wr), .z_wr(z_wr),
        .mdr_wr(mdr_wr), .rf_wr(rf_wr), .wb_sel(wb_sel), .state(state),
        .halted(halted), .err(err)
`ifdef MC_SEQ_PERF_EN
        , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, record what the outputs must be, then advance past the edge.
    task automatic applyStimulus(input logic r, input logic [2:0] op, input logic lk,
                                 input logic br, input logic rdy, input outs_t e, input string nm);
        rst       = r;
        op_class  = op;
        link      = lk;
        br_taken  = br;
        mem_ready = rdy;
        expQ.push_back(e);
        nameQ.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    function automatic outs_t idleOut(input logic [2:0] st);
        outs_t o;
        o = '0;
        o.state = st;
        o.err = mErr;
        return o;
    endfunction

    task automatic doReset(input int n);
        outs_t z;
        z = '0;
        repeat (n) applyStimulus(1'b1, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                                 1'($urandom), z, "reset");
        mErr = 2'd0;
    endtask

    task automatic haltPhase(input int n);
        outs_t h;
        h = idleOut(3'd5);
        h.halted = 1'b1;
        repeat (n) applyStimulus(1'b0, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                                 1'($urandom), h, "halt");
    endtask

    // A memory-handshake phase: 'waits' idle cycles then ready, or a timeout after TIMEOUT+1 idle cycles.
    task automatic waitPhase(input logic [2:0] op, input bit randOp, input logic lk, input logic br,
                             input int waits, input outs_t busy, input outs_t done,
                             input string nm, output bit timedOut);
        logic [2:0] o;
        timedOut = 0;
        for (int k = 0; k <= waits; k++) begin
            o = randOp ? 3'($urandom_range(0, 7)) : op;
            if (k == waits) begin
                applyStimulus(1'b0, o, lk, br, 1'b1, done, nm);
            end else begin
                applyStimulus(1'b0, o, lk, br, 1'b0, busy, nm);
                if (TIMEOUT != 0 && k == TIMEOUT) begin
                    timedOut = 1;
                    mErr = 2'd2;
                    break;
                end
            end
        end
    endtask

    task automatic runInstr(input logic [2:0] op, input logic lk, input logic br,
                            input int ifWait, input int memWait);
        outs_t busy, done, e;
        bit    to;
        busy = idleOut(3'd0);
        busy.memReq = 1'b1;
        busy.pcRd = 1'b1;
        done = busy;
        done.irWr = 1'b1;
        done.pcWr = 1'b1;
        waitPhase(op, 1'b1, lk, br, ifWait, busy, done, "IF", to);
        if (to) begin
            haltPhase(3);
            doReset(2);
            return;
        end

        e = idleOut(3'd1);
        e.abWr = 1'b1;
        applyStimulus(1'b0, op, lk, br, 1'($urandom), e, "ID");
        if (op >= 3'd5) begin
            if (op != 3'd5) mErr = 2'd1;
            haltPhase(3);
            doReset(1);
            return;
        end

        e = idleOut(3'd2);
        if (op <= 3'd2) e.zWr = 1'b1;
        if (op == 3'd3) begin
            e.pcWr = br;
            e.pcSrc = 2'd1;
        end
        if (op == 3'd4) begin
            e.pcWr = 1'b1;
            e.pcSrc = 2'd2;
        end
        applyStimulus(1'b0, op, lk, br, 1'($urandom), e, "EX");
        if (op == 3'd3 || (op == 3'd4 && !lk)) return;

        if (op == 3'd1 || op == 3'd2) begin
            busy = idleOut(3'd3);
            busy.memReq = 1'b1;
            busy.memWe = (op == 3'd2);
            done = busy;
            done.mdrWr = (op == 3'd1);
            waitPhase(op, 1'b0, lk, br, memWait, busy, done, "MEM", to);
            if (to) begin
                haltPhase(3);
                doReset(2);
                return;
            end
            if (op == 3'd2) return;
        end

        e = idleOut(3'd4);
        e.rfWr = 1'b1;
        e.wbSel = (op == 3'd1) ? 2'd1 : ((op == 3'd4) ? 2'd2 : 2'd0);
        applyStimulus(1'b0, op, lk, br, 1'($urandom), e, "WB");
    endtask

    function automatic int randWait();
        int r;
        r = $urandom_range(0, 9);
        if (r < 5) return 0;
        if (r < 8) return $urandom_range(1, 3);
        return $urandom_range(4, 6);
    endfunction

    function automatic logic [2:0] randOp();
        int r;
        r = $urandom_range(0, 19);
        if (r < 17) return 3'(r % 5);
        return 3'($urandom_range(5, 7));
    endfunction

    task automatic checkOutput(input outs_t e, input string nm);
        outs_t a;
        a = {mem_req, mem_we, pc_wr, pc_rd, pc_src, ir_wr, ab_wr, z_wr, mdr_wr, rf_wr,
             wb_sel, state, halted, err};
        testsRun++;
        if (a !== e) begin
            testsFailed++;
            $display("[TB] FAIL %s @%0t: got %b required %b (state got %0d required %0d)",
                     nm, $time, a, e, a.state, e.state);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                checkOutput(expQ.pop_front(), nameQ.pop_front());
            end
        end
    end

    initial begin : driver
        rst = 1'b1;
        op_class = 3'd0;
        link = 1'b0;
        br_taken = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        doReset(2);
        runInstr(3'd0, 1'b0, 1'b0, 0, 0);
        runInstr(3'd1, 1'b0, 1'b0, 0, 3);
        runInstr(3'd2, 1'b0, 1'b1, 0, 0);
        runInstr(3'd3, 1'b0, 1'b0, 0, 0);
        runInstr(3'd3, 1'b1, 1'b1, 0, 0);
        runInstr(3'd4, 1'b1, 1'b0, 0, 0);
        runInstr(3'd4, 1'b0, 1'b1, 0, 0);
        runInstr(3'd0, 1'b0, 1'b0, 4, 0);
        runInstr(3'd0, 1'b0, 1'b0, 5, 0);
        runInstr(3'd1, 1'b0, 1'b0, 0, 5);
        runInstr(3'd2, 1'b0, 1'b0, 0, 4);
        runInstr(3'd7, 1'b0, 1'b0, 0, 0);
        runInstr(3'd5, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 200; i++) begin
            runInstr(randOp(), 1'($urandom), 1'($urandom), randWait(), randWait());
        end
        driverDone = 1;
    end

    initial begin : finisher
        int budget;
        budget = 0;
        while (!driverDone && budget < 20000) begin
            @(posedge clk);
            budget++;
        end
        if (!driverDone) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL driver_timeout: got unfinished required finished");
        end
        repeat (4) @(posedge clk);
        if (expQ.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL scoreboard_drain: got %0d left required 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
